// File: rtl/int_entrywise_product_arbiter.sv
// int_entrywise_product_arbiter
// Round-robin arbiter that shares one int entrywise-product unit between
// NUM_REQ requesters. Each requester's a/b operand streams are joined and
// issued together; the issuing requester ID is queued in an in-flight tag FIFO
// so that each returned product is routed back to its owner in order.
// Optional feature macro: INT_EP_ARB_PERF_COUNTERS_EN adds saturating
// per-requester issue counters and a HOLD-cycle counter.
module int_entrywise_product_arbiter #(
    parameter int  NUM_REQ         = 4,
    parameter int  A_WIDTH         = 8,
    parameter int  B_WIDTH         = 8,
    parameter int  A_DIM_0_B_DIM_0 = 8,
    parameter int  TAG_FIFO_DEPTH  = 4,
    localparam int OutWidth        = A_WIDTH + B_WIDTH
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic [NUM_REQ-1:0][A_DIM_0_B_DIM_0-1:0][A_WIDTH-1:0]   req_data_a,
    input  logic [NUM_REQ-1:0]                                     req_valid_a,
    output logic [NUM_REQ-1:0]                                     req_ready_a,
    input  logic [NUM_REQ-1:0][A_DIM_0_B_DIM_0-1:0][B_WIDTH-1:0]   req_data_b,
    input  logic [NUM_REQ-1:0]                                     req_valid_b,
    output logic [NUM_REQ-1:0]                                     req_ready_b,
    output logic [A_DIM_0_B_DIM_0-1:0][A_WIDTH-1:0]                mul_data_a,
    output logic [A_DIM_0_B_DIM_0-1:0][B_WIDTH-1:0]                mul_data_b,
    output logic                                                   mul_valid,
    input  logic                                                   mul_ready,
    input  logic [A_DIM_0_B_DIM_0-1:0][OutWidth-1:0]               res_data,
    input  logic                                                   res_valid,
    output logic                                                   res_ready,
    output logic [A_DIM_0_B_DIM_0-1:0][OutWidth-1:0]               out_data,
    output logic [NUM_REQ-1:0]                                     out_valid,
    input  logic [NUM_REQ-1:0]                                     out_ready,
    output logic                                                   busy
`ifdef INT_EP_ARB_PERF_COUNTERS_EN
    ,
    output logic [NUM_REQ-1:0][31:0]                               perf_grant_cnt,
    output logic [31:0]                                            perf_stall_cnt
`endif
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(TAG_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t             state_reg;
    logic [ID_W-1:0]    rr_ptr_reg;
    logic [ID_W-1:0]    lock_id_reg;

    logic [ID_W-1:0]    tag_mem [TAG_FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;

    logic [NUM_REQ-1:0] eligible;
    logic [ID_W-1:0]    grant;
    logic               any_eligible;
    int                 idx;
    logic [ID_W-1:0]    sel_id;
    logic [ID_W-1:0]    head;
    logic               tag_full;
    logic               tag_empty;
    logic               fire;
    logic               pop;

    // Advance a requester index by one, wrapping at NUM_REQ.
    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] x);
        return (x == ID_W'(NUM_REQ - 1)) ? '0 : x + ID_W'(1);
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
            // a and b are consumed only together, so both must be offered.
            assign eligible[gi] = req_valid_a[gi] & req_valid_b[gi];
        end
    endgenerate

    // Round-robin search: first eligible index at or after rr_ptr_reg.
    // Scanning from the far end lets the nearest candidate win last.
    always_comb begin
        grant        = '0;
        any_eligible = 1'b0;
        idx          = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_reg) + k) % NUM_REQ;
            if (eligible[idx]) begin
                grant        = ID_W'(idx);
                any_eligible = 1'b1;
            end
        end
    end

    assign tag_full  = (count_reg == CNT_W'(TAG_FIFO_DEPTH));
    assign tag_empty = (count_reg == '0);

    // In HOLD the stalled requester keeps ownership until accepted.
    assign sel_id    = (state_reg == ST_HOLD) ? lock_id_reg : grant;

    // A full tag FIFO blocks new issues even if a pop happens this cycle.
    assign mul_valid = !rst && ((state_reg == ST_HOLD) || (any_eligible && !tag_full));
    assign fire      = mul_valid && mul_ready;

    assign mul_data_a = rst ? '0 : req_data_a[sel_id];
    assign mul_data_b = rst ? '0 : req_data_b[sel_id];

    assign head      = tag_mem[rd_ptr_reg];
    assign res_ready = !rst && !tag_empty && out_ready[head];
    assign pop       = res_valid && res_ready;
    assign out_data  = rst ? '0 : res_data;
    assign busy      = mul_valid || (!rst && !tag_empty);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_route
            assign req_ready_a[gi] = fire && (sel_id == ID_W'(gi));
            assign req_ready_b[gi] = fire && (sel_id == ID_W'(gi));
            // A result arriving with no outstanding tag is never claimed.
            assign out_valid[gi]   = !rst && res_valid && !tag_empty && (head == ID_W'(gi));
        end
    endgenerate

    // Arbitration FSM: rotate priority past each issued requester; on a stall
    // lock the current grant so data and valid stay stable until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_ARB;
            rr_ptr_reg  <= '0;
            lock_id_reg <= '0;
        end else begin
            case (state_reg)
                ST_ARB: begin
                    if (fire) begin
                        rr_ptr_reg <= next_id(grant);
                    end else if (mul_valid) begin
                        lock_id_reg <= grant;
                        state_reg   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (mul_ready) begin
                        rr_ptr_reg <= next_id(lock_id_reg);
                        state_reg  <= ST_ARB;
                    end
                end
                default: state_reg <= ST_ARB;
            endcase
        end
    end

    // Tag storage: the owner ID of every accepted issue, in issue order.
    always_ff @(posedge clk) begin
        if (fire) begin
            tag_mem[wr_ptr_reg] <= sel_id;
        end
    end

    // Tag FIFO pointers and occupancy; simultaneous push and pop cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (fire) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({fire, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

`ifdef INT_EP_ARB_PERF_COUNTERS_EN
    logic [NUM_REQ-1:0][31:0] perf_grant_cnt_reg;
    logic [31:0]              perf_stall_cnt_reg;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
            // Saturating count of issues accepted for this requester.
            always_ff @(posedge clk) begin
                if (rst) begin
                    perf_grant_cnt_reg[gi] <= '0;
                end else if (fire && (sel_id == ID_W'(gi)) && (perf_grant_cnt_reg[gi] != '1)) begin
                    perf_grant_cnt_reg[gi] <= perf_grant_cnt_reg[gi] + 32'd1;
                end
            end
        end
    endgenerate

    // Saturating count of cycles spent waiting in HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt_reg <= '0;
        end else if ((state_reg == ST_HOLD) && (perf_stall_cnt_reg != '1)) begin
            perf_stall_cnt_reg <= perf_stall_cnt_reg + 32'd1;
        end
    end

    assign perf_grant_cnt = perf_grant_cnt_reg;
    assign perf_stall_cnt = perf_stall_cnt_reg;
`endif

endmodule

// File: tb/tb_int_entrywise_product_arbiter.sv
// Testbench for int_entrywise_product_arbiter: directed stimulus, a behavioural
// shared product unit, and a scoreboard monitor checking every routed result.
module tb_int_entrywise_product_arbiter;

    localparam int NR = 4;
    localparam int AW = 8;
    localparam int BW = 8;
    localparam int N  = 8;
    localparam int D  = 4;
    localparam int OW = AW + BW;

    typedef logic [N-1:0][AW-1:0] va_t;
    typedef logic [N-1:0][BW-1:0] vb_t;
    typedef logic [N-1:0][OW-1:0] vo_t;
    typedef struct {
        int  id;
        vo_t data;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [NR-1:0][N-1:0][AW-1:0] da;
    logic [NR-1:0][N-1:0][BW-1:0] db;
    logic [NR-1:0]       valid_a, valid_b, ready_a, ready_b;
    va_t                 mul_data_a;
    vb_t                 mul_data_b;
    logic                mul_valid, mul_ready;
    vo_t                 res_data;
    logic                res_valid, res_ready;
    vo_t                 out_data;
    logic [NR-1:0]       out_valid, out_ready;
    logic                busy;
`ifdef INT_EP_ARB_PERF_COUNTERS_EN
    logic [NR-1:0][31:0] perf_grant_cnt;
    logic [31:0]         perf_stall_cnt;
`endif

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    vo_t  unit_q[$];
    logic unit_has  = 1'b0;
    vo_t  unit_head = '0;
    logic res_gate  = 1'b0;

    assign res_valid = res_gate & unit_has;
    assign res_data  = unit_head;

    always #5 clk = ~clk;

    int_entrywise_product_arbiter #(
        .NUM_REQ(NR), .A_WIDTH(AW), .B_WIDTH(BW),
        .A_DIM_0_B_DIM_0(N), .TAG_FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .rst(rst),
        .req_data_a(da), .req_valid_a(valid_a), .req_ready_a(ready_a),
        .req_data_b(db), .req_valid_b(valid_b), .req_ready_b(ready_b),
        .mul_data_a(mul_data_a), .mul_data_b(mul_data_b),
        .mul_valid(mul_valid), .mul_ready(mul_ready),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
`ifdef INT_EP_ARB_PERF_COUNTERS_EN
        ,
        .perf_grant_cnt(perf_grant_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    function automatic vo_t prod(input va_t a, input vb_t b);
        vo_t p;
        int  x;
        p = '0;
        for (int e = 0; e < N; e++) begin
            x    = int'($signed(a[e])) * int'($signed(b[e]));
            p[e] = OW'(x);
        end
        return p;
    endfunction

    function automatic logic [NR-1:0] oh(input int i);
        logic [NR-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int id);
        exp_t e;
        e.id   = id;
        e.data = prod(da[id], db[id]);
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 60 && exp_q.size() != 0; c++) tick();
        check("drain_left", 64'(exp_q.size()), 64'(0));
    endtask

    // Behavioural shared product unit: one-cycle latency, in-order results.
    always @(posedge clk) begin
        if (rst) begin
            unit_q.delete();
        end else begin
            if (res_valid && res_ready) void'(unit_q.pop_front());
            if (mul_valid && mul_ready) unit_q.push_back(prod(mul_data_a, mul_data_b));
        end
        unit_has  <= (unit_q.size() != 0);
        unit_head <= (unit_q.size() != 0) ? unit_q[0] : '0;
    end

    // Scoreboard monitor: every accepted result must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int i = 0; i < NR; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_result owner=%0d out_valid=%b required=none", i, out_valid);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_valid !== oh(e.id) || out_data !== e.data) begin
                            bad++;
                            $display("FAIL result out_valid=%b data=%h required out_valid=%b data=%h",
                                     out_valid, out_data, oh(e.id), e.data);
                        end else begin
                            $display("result owner=%0d data=%h", e.id, out_data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vo_t c12;
        rst       = 1'b1;
        valid_a   = '0;
        valid_b   = '0;
        mul_ready = 1'b0;
        out_ready = '0;
        for (int i = 0; i < NR; i++) begin
            for (int e = 0; e < N; e++) begin
                da[i][e] = AW'(i * 5 + e + 1);
                db[i][e] = BW'(e - 3 - i);
            end
        end

        // Reset: everything quiet even with requests offered.
        valid_a = '1; valid_b = '1; mul_ready = 1'b1; out_ready = '1; res_gate = 1'b1;
        tick(); tick(); settle();
        check("rst_mul_valid", 64'(mul_valid), 64'(0));
        check("rst_ready_a", 64'(ready_a), 64'(0));
        check("rst_ready_b", 64'(ready_b), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_res_ready", 64'(res_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_mul_data_a", 64'(mul_data_a), 64'(0));
        valid_a = '0; valid_b = '0; rst = 1'b0;
        tick(); settle();
        check("idle_busy", 64'(busy), 64'(0));

        // Only requester 2: three back-to-back issues, products all -12.
        for (int e = 0; e < N; e++) begin
            da[2][e]  = 8'd3;
            db[2][e]  = 8'hFC;
            c12[e]    = 16'hFFF4;
        end
        valid_a = 4'b0100; valid_b = 4'b0100;
        settle();
        for (int k = 0; k < 3; k++) begin
            check("t1_mul_valid", 64'(mul_valid), 64'(1));
            check("t1_ready_a", 64'(ready_a), 64'(4'b0100));
            check("t1_ready_b", 64'(ready_b), 64'(4'b0100));
            exp_q.push_back('{id: 2, data: c12});
            $display("issue req=2 k=%0d", k);
            tick();
        end
        valid_a = '0; valid_b = '0;
        settle();
        check("t1_idle", 64'(mul_valid), 64'(0));
        drain();

        // All eligible: grant order 0,1,2,3,0,1.
        do_reset();
        valid_a = '1; valid_b = '1;
        settle();
        for (int k = 0; k < 6; k++) begin
            check("t2_grant", 64'(ready_a), 64'(oh(k % NR)));
            push_exp(k % NR);
            $display("issue req=%0d", k % NR);
            tick();
        end
        valid_a = '0; valid_b = '0;
        drain();

        // Stall: requester 1 held for 3 cycles, then requester 0 follows.
        do_reset();
        valid_a = 4'b0001; valid_b = 4'b0001;
        settle();
        check("t3_pre_grant", 64'(ready_a), 64'(4'b0001));
        push_exp(0);
        tick();
        valid_a = 4'b0011; valid_b = 4'b0011; mul_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("t3_hold_valid", 64'(mul_valid), 64'(1));
            check("t3_hold_ready", 64'(ready_a), 64'(0));
            check("t3_hold_data_a", 64'(mul_data_a), 64'(va_t'(da[1])));
            check("t3_hold_data_b", 64'(mul_data_b), 64'(vb_t'(db[1])));
            tick();
        end
        mul_ready = 1'b1;
        settle();
        check("t3_fire_req1", 64'(ready_a), 64'(4'b0010));
        push_exp(1);
        tick(); settle();
        check("t3_next_req0", 64'(ready_a), 64'(4'b0001));
        push_exp(0);
        tick();
        valid_a = '0; valid_b = '0;
        drain();

        // Tag FIFO full: exactly 4 issues, no bypass on the popping cycle.
        do_reset();
        res_gate = 1'b0;
        valid_a = '1; valid_b = '1;
        settle();
        for (int k = 0; k < 6; k++) begin
            check("t4_mul_valid", 64'(mul_valid), 64'(k < 4));
            if (k < 4) push_exp(k);
            tick();
        end
        res_gate = 1'b1;
        settle();
        check("t4_no_bypass", 64'(mul_valid), 64'(0));
        check("t4_res_ready", 64'(res_ready), 64'(1));
        tick();
        res_gate = 1'b0;
        settle();
        check("t4_resume", 64'(mul_valid), 64'(1));
        check("t4_resume_grant", 64'(ready_a), 64'(4'b0001));
        push_exp(0);
        tick();
        valid_a = '0; valid_b = '0; res_gate = 1'b1;
        drain();

        // Head owner 3 not ready: result waits, then exactly one pop.
        do_reset();
        out_ready = 4'b0111;
        valid_a = 4'b1000; valid_b = 4'b1000;
        settle();
        check("t5_grant", 64'(ready_a), 64'(4'b1000));
        push_exp(3);
        tick(); settle();
        check("t5_grant2", 64'(ready_a), 64'(4'b1000));
        push_exp(3);
        tick();
        valid_a = '0; valid_b = '0;
        for (int k = 0; k < 5; k++) begin
            settle();
            check("t5_res_ready", 64'(res_ready), 64'(0));
            check("t5_out_valid", 64'(out_valid), 64'(4'b1000));
            tick();
        end
        out_ready = '1;
        settle();
        check("t5_pop_ready", 64'(res_ready), 64'(1));
        tick();
        out_ready = 4'b0111;
        settle();
        check("t5_one_left_valid", 64'(out_valid), 64'(4'b1000));
        check("t5_one_left_busy", 64'(busy), 64'(1));
        tick();
        out_ready = '1;
        drain();
        settle();
        check("t5_empty_busy", 64'(busy), 64'(0));

        // Reset with 3 in flight while in HOLD.
        do_reset();
        res_gate = 1'b0;
        valid_a = '1; valid_b = '1;
        settle();
        for (int k = 0; k < 3; k++) begin
            push_exp(k);
            tick();
        end
        mul_ready = 1'b0;
        settle();
        check("t6_stall_grant", 64'(mul_data_a), 64'(va_t'(da[3])));
        tick();
        rst = 1'b1;
        res_gate = 1'b1;
        exp_q.delete();
        settle();
        check("t6_rst_mul_valid", 64'(mul_valid), 64'(0));
        check("t6_rst_busy", 64'(busy), 64'(0));
        check("t6_rst_res_ready", 64'(res_ready), 64'(0));
        check("t6_rst_out_valid", 64'(out_valid), 64'(0));
        check("t6_rst_out_data", 64'(out_data), 64'(0));
        tick();
        rst = 1'b0;
        valid_a = '0; valid_b = '0; mul_ready = 1'b1;
        settle();
        check("t6_post_busy", 64'(busy), 64'(0));
`ifdef INT_EP_ARB_PERF_COUNTERS_EN
        check("t6_perf_grant", 64'(perf_grant_cnt[0]), 64'(0));
        check("t6_perf_stall", 64'(perf_stall_cnt), 64'(0));
`endif
        valid_a = '1; valid_b = '1;
        settle();
        check("t6_first_grant", 64'(ready_a), 64'(4'b0001));
        push_exp(0);
        tick();
        valid_a = '0; valid_b = '0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
